// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter in front of the byte-addressed data memory.
// Each grant performs one checked 64-bit access and returns a registered ack/err/rdata.
module data_mem_arbiter #(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int MEM_BYTES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [DATA_W-1:0] Write_Data,
    output logic              MemWrite,
    output logic              MemRead,
    input  logic [DATA_W-1:0] Read_Data
);

    // Handshake: a requester raises reqN with we/addr/wdata stable and holds it
    // until ackN pulses for one cycle; fields are latched at the grant edge, so
    // dropping reqN afterwards does not cancel the access. err and rdata are
    // only meaningful in the ack cycle.

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_last_grant;
    logic              r_win;
    logic              r_ack0;
    logic              r_ack1;
    logic              r_err;
    logic [DATA_W-1:0] r_rdata;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_mem_write;
    logic              r_mem_read;

    logic              w_any;
    logic              w_pick1;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic [ADDR_W:0]   w_end;
    logic              w_legal;

    assign w_any       = req0 | req1;
    assign w_pick1     = req1 & (~req0 | ~r_last_grant);
    assign w_sel_we    = w_pick1 ? we1    : we0;
    assign w_sel_addr  = w_pick1 ? addr1  : addr0;
    assign w_sel_wdata = w_pick1 ? wdata1 : wdata0;

    // One extra bit so addresses near the top of the space cannot wrap into range.
    assign w_end   = {1'b0, w_sel_addr} + (ADDR_W+1)'(8);
    assign w_legal = (w_sel_addr[2:0] == 3'b000) && (w_end <= (ADDR_W+1)'(MEM_BYTES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_win        <= 1'b0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_err        <= 1'b0;
            r_rdata      <= '0;
            r_mem_addr   <= '0;
            r_wdata      <= '0;
            r_mem_write  <= 1'b0;
            r_mem_read   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ack0 <= 1'b0;
                    r_ack1 <= 1'b0;
                    r_err  <= 1'b0;
                    if (w_any) begin
                        r_win <= w_pick1;
                        if (req0 && req1) begin
                            r_last_grant <= w_pick1;
                        end
                        if (w_legal) begin
                            // Memory-facing registers only ever take legal addresses.
                            r_mem_addr  <= w_sel_addr;
                            r_wdata     <= w_sel_wdata;
                            r_mem_write <= w_sel_we;
                            r_mem_read  <= ~w_sel_we;
                            r_state     <= ST_ACCESS;
                        end else begin
                            r_ack0  <= ~w_pick1;
                            r_ack1  <= w_pick1;
                            r_err   <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (r_mem_read) begin
                        r_rdata <= Read_Data;
                    end
                    r_mem_write <= 1'b0;
                    r_mem_read  <= 1'b0;
                    r_ack0      <= ~r_win;
                    r_ack1      <= r_win;
                    r_err       <= 1'b0;
                    r_state     <= ST_DONE;
                end
                ST_DONE: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_ack0      <= 1'b0;
                    r_ack1      <= 1'b0;
                    r_err       <= 1'b0;
                    r_mem_write <= 1'b0;
                    r_mem_read  <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack0       = r_ack0;
    assign ack1       = r_ack1;
    assign err        = r_err;
    assign rdata      = r_rdata;
    assign busy       = (r_state != ST_IDLE);
    assign Mem_Addr   = r_mem_addr;
    assign Write_Data = r_wdata;
    assign MemWrite   = r_mem_write;
    assign MemRead    = r_mem_read;

    a_one_ack:      assert property (@(posedge clk) disable iff (!rst_n) !(ack0 && ack1));
    a_err_with_ack: assert property (@(posedge clk) disable iff (!rst_n) err |-> (ack0 || ack1));
    a_one_strobe:   assert property (@(posedge clk) disable iff (!rst_n) !(MemRead && MemWrite));

endmodule
